beta_mem_stage: RTL
===================

Name: beta_mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Takes the execute result (ALU address or value, store data, memory-op controls) over a valid/ready handshake.
- Runs one data-memory transaction per load or store using a wait-ready / wait-valid FSM (IDLE, WRDY, WVLD, encoded 2'b00/01/10).
- Emits a single-cycle writeback record (register write or pass-through result) to the writeback stage.

Parameters:
- XLEN, 32, datapath and address width.
- RF_ADDR_W, 5, destination register index width.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- exe_valid_i  input  1  execute result valid.
- exe_ready_o  output  1  stage can accept; equals (state==IDLE).
- exe_res_i  input  XLEN  ALU result; the address for memory ops.
- exe_store_data_i  input  XLEN  rs2 value for stores.
- exe_mem_op_en_i  input  1  memory operation requested.
- exe_mem_op_i  input  1  0=load, 1=store.
- exe_mem_op_size_i  input  2  00 word, 01 half, 10 byte, 11 illegal.
- exe_load_unsigned_i  input  1  1: zero-extend loads, 0: sign-extend.
- exe_reg_wr_en_i  input  1  instruction writes rd.
- exe_rd_i  input  RF_ADDR_W  destination register.
- dmem_req_valid_o  output  1  request valid.
- dmem_req_ready_i  input  1  memory accepts request.
- dmem_addr_o  output  XLEN  word-aligned address (low 2 bits 0).
- dmem_we_o  output  1  1=write.
- dmem_be_o  output  4  byte enables.
- dmem_wdata_o  output  XLEN  lane-replicated store data.
- dmem_rsp_valid_i  input  1  read data / write ack valid.
- dmem_rdata_i  input  XLEN  read word.
- wb_valid_o  output  1  one-cycle writeback pulse.
- wb_reg_wr_en_o  output  1  write rd.
- wb_rd_o  output  RF_ADDR_W  destination register.
- wb_data_o  output  XLEN  writeback value.
- wb_misaligned_o  output  1  access fault, qualified by wb_valid_o.

Behaviour:
- Reset (synchronous, rst_i=1 at a clock edge):
  - State goes to IDLE.
  - All outputs go to 0 except exe_ready_o, which is 1 in the first post-reset cycle.
  - An in-flight transaction is abandoned. A dmem_rsp_valid_i arriving after reset while in IDLE is ignored.
- Accept: the handshake completes when exe_valid_i && exe_ready_o at a rising edge. Inputs are captured into internal registers at that edge.
- Non-memory op (mem_op_en=0): stays IDLE. Next cycle wb_valid_o=1, wb_data_o=exe_res_i, wb_reg_wr_en_o=exe_reg_wr_en_i, wb_misaligned_o=0. Latency 1.
- Misalignment check: the access is misaligned when any of the following holds. No dmem request is issued. Next cycle wb_valid_o=1, wb_misaligned_o=1, wb_reg_wr_en_o=0. Stays IDLE.
  - size=11.
  - half with addr[0]=1.
  - word with addr[1:0]!=0.
- Aligned memory op:
  - Next cycle: state=WRDY, dmem_req_valid_o=1.
  - Address, we, be and wdata are held stable until accepted.
- WRDY: when dmem_req_ready_i=1, go to WVLD and drop dmem_req_valid_o the following cycle. Otherwise hold.
- WVLD:
  - dmem_rsp_valid_i is sampled only in this state.
  - On rsp, go to IDLE and pulse wb_valid_o the next cycle.
  - Load: wb_reg_wr_en_o = captured reg_wr_en.
  - Store: wb_reg_wr_en_o=0 and wb_data_o=0.
- Minimum memory latency: accept at T, req_valid at T+1, ready at T+1 gives WVLD at T+2, rsp at T+2 gives wb_valid at T+3.
- Byte enables:
  - word: 1111.
  - half: addr[1] ? 1100 : 0011.
  - byte: 0001 << addr[1:0].
- Store data lanes:
  - word: unchanged.
  - half: {d[15:0],d[15:0]}.
  - byte: {4{d[7:0]}}.
- Load extraction: shift rdata right by 8*addr[1:0], take the low 8 or 16 bits (or all 32), then extend per load_unsigned.
- Back-to-back throughput: exe_ready_o reasserts in the same cycle wb_valid_o is high for a memory op. A new instruction may therefore be accepted in the cycle its predecessor writes back.

Test Plan:
- Non-memory pass-through: accept res=0x1234_5678, rd=7, reg_wr_en=1 -> next cycle wb_valid=1, wb_data=0x1234_5678, wb_rd=7, no dmem_req_valid.
- Store byte with zero-wait memory: addr=0x1003, data=0xAABBCCDD, ready and rsp with zero wait -> dmem_addr=0x1000, be=1000, wdata=0xDDDDDDDD, we=1; wb_valid at T+3 with wb_reg_wr_en=0.
- Signed half load with stalls: addr=0x2002, rdata=0x8001_0000, ready delayed 3 cycles, rsp delayed 2 -> req_valid held 4 cycles with stable address; wb_data=0xFFFF_8001. Repeat unsigned -> 0x0000_8001.
- Misaligned word load: addr=0x3001 -> no request issued; next cycle wb_valid=1, wb_misaligned=1, wb_reg_wr_en=0. Repeat size=11 -> same response.
- Reset in WVLD: assert rst_i for one cycle while in WVLD, then assert rsp_valid -> no wb_valid; outputs 0; exe_ready_o=1.
- Back-to-back: word load 0x10 (rdata 0xCAFEF00D) followed immediately by a non-memory op -> second instruction accepted in the load's wb cycle; wb pulses in order with data 0xCAFEF00D, then the ALU value.

Source files
------------

// File: rtl/beta_mem_stage.sv
// beta_mem_stage: memory-access stage between execute and writeback.
// One dmem transaction per load/store; single-cycle writeback record.
module beta_mem_stage #(
   parameter int XLEN      = 32,
   parameter int RF_ADDR_W = 5
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 exe_valid_i,
   output logic                 exe_ready_o,
   input  logic [XLEN-1:0]      exe_res_i,
   input  logic [XLEN-1:0]      exe_store_data_i,
   input  logic                 exe_mem_op_en_i,
   input  logic                 exe_mem_op_i,
   input  logic [1:0]           exe_mem_op_size_i,
   input  logic                 exe_load_unsigned_i,
   input  logic                 exe_reg_wr_en_i,
   input  logic [RF_ADDR_W-1:0] exe_rd_i,
   output logic                 dmem_req_valid_o,
   input  logic                 dmem_req_ready_i,
   output logic [XLEN-1:0]      dmem_addr_o,
   output logic                 dmem_we_o,
   output logic [3:0]           dmem_be_o,
   output logic [XLEN-1:0]      dmem_wdata_o,
   input  logic                 dmem_rsp_valid_i,
   input  logic [XLEN-1:0]      dmem_rdata_i,
   output logic                 wb_valid_o,
   output logic                 wb_reg_wr_en_o,
   output logic [RF_ADDR_W-1:0] wb_rd_o,
   output logic [XLEN-1:0]      wb_data_o,
   output logic                 wb_misaligned_o
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      WRDY = 2'b01,
      WVLD = 2'b10
   } state_e;

   state_e state_q, state_d;

   logic [XLEN-1:0]      addr_q, addr_d;
   logic [XLEN-1:0]      wdata_q, wdata_d;
   logic [3:0]           be_q, be_d;
   logic                 we_q, we_d;
   logic [1:0]           size_q, size_d;
   logic                 lu_q, lu_d;
   logic                 rwe_q, rwe_d;
   logic [RF_ADDR_W-1:0] rd_q, rd_d;

   logic                 wb_valid_q, wb_valid_d;
   logic                 wb_rwe_q, wb_rwe_d;
   logic [RF_ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic [XLEN-1:0]      wb_data_q, wb_data_d;
   logic                 wb_mis_q, wb_mis_d;

   logic                 mis;
   logic [3:0]           be_new;
   logic [XLEN-1:0]      wdata_new;
   logic [XLEN-1:0]      rd_shift;
   logic [XLEN-1:0]      load_val;

   assign exe_ready_o      = (state_q == IDLE);
   assign dmem_req_valid_o = (state_q == WRDY);
   assign dmem_addr_o      = {addr_q[XLEN-1:2], 2'b00};
   assign dmem_we_o        = we_q;
   assign dmem_be_o        = be_q;
   assign dmem_wdata_o     = wdata_q;
   assign wb_valid_o       = wb_valid_q;
   assign wb_reg_wr_en_o   = wb_rwe_q;
   assign wb_rd_o          = wb_rd_q;
   assign wb_data_o        = wb_data_q;
   assign wb_misaligned_o  = wb_mis_q;

   // Alignment check, byte lanes and replicated store data for the new op
   always_comb begin
      mis       = 1'b0;
      be_new    = 4'b1111;
      wdata_new = exe_store_data_i;
      case (exe_mem_op_size_i)
         2'b00: mis = |exe_res_i[1:0];
         2'b01: begin
            mis       = exe_res_i[0];
            be_new    = exe_res_i[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{exe_store_data_i[15:0]}};
         end
         2'b10: begin
            be_new    = 4'b0001 << exe_res_i[1:0];
            wdata_new = {4{exe_store_data_i[7:0]}};
         end
         default: mis = 1'b1;
      endcase
   end

   // Align the read word to the access and extend to XLEN
   always_comb begin
      rd_shift = dmem_rdata_i >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'b10: load_val = lu_q
            ? {{(XLEN-8){1'b0}}, rd_shift[7:0]}
            : {{(XLEN-8){rd_shift[7]}}, rd_shift[7:0]};
         2'b01: load_val = lu_q
            ? {{(XLEN-16){1'b0}}, rd_shift[15:0]}
            : {{(XLEN-16){rd_shift[15]}}, rd_shift[15:0]};
         default: load_val = rd_shift;
      endcase
   end

   // Handshake FSM plus capture and writeback record update
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      be_d       = be_q;
      we_d       = we_q;
      size_d     = size_q;
      lu_d       = lu_q;
      rwe_d      = rwe_q;
      rd_d       = rd_q;
      wb_valid_d = 1'b0;
      wb_rwe_d   = wb_rwe_q;
      wb_rd_d    = wb_rd_q;
      wb_data_d  = wb_data_q;
      wb_mis_d   = wb_mis_q;
      case (state_q)
         IDLE: begin
            if (exe_valid_i) begin
               if (!exe_mem_op_en_i) begin
                  wb_valid_d = 1'b1;
                  wb_rwe_d   = exe_reg_wr_en_i;
                  wb_rd_d    = exe_rd_i;
                  wb_data_d  = exe_res_i;
                  wb_mis_d   = 1'b0;
               end else if (mis) begin
                  wb_valid_d = 1'b1;
                  wb_rwe_d   = 1'b0;
                  wb_rd_d    = exe_rd_i;
                  wb_data_d  = '0;
                  wb_mis_d   = 1'b1;
               end else begin
                  state_d = WRDY;
                  addr_d  = exe_res_i;
                  wdata_d = wdata_new;
                  be_d    = be_new;
                  we_d    = exe_mem_op_i;
                  size_d  = exe_mem_op_size_i;
                  lu_d    = exe_load_unsigned_i;
                  rwe_d   = exe_reg_wr_en_i;
                  rd_d    = exe_rd_i;
               end
            end
         end
         WRDY: begin
            if (dmem_req_ready_i) begin
               state_d = WVLD;
            end
         end
         WVLD: begin
            if (dmem_rsp_valid_i) begin
               state_d    = IDLE;
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_q;
               wb_mis_d   = 1'b0;
               wb_rwe_d   = we_q ? 1'b0 : rwe_q;
               wb_data_d  = we_q ? '0 : load_val;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         wdata_q    <= '0;
         be_q       <= '0;
         we_q       <= 1'b0;
         size_q     <= '0;
         lu_q       <= 1'b0;
         rwe_q      <= 1'b0;
         rd_q       <= '0;
         wb_valid_q <= 1'b0;
         wb_rwe_q   <= 1'b0;
         wb_rd_q    <= '0;
         wb_data_q  <= '0;
         wb_mis_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         be_q       <= be_d;
         we_q       <= we_d;
         size_q     <= size_d;
         lu_q       <= lu_d;
         rwe_q      <= rwe_d;
         rd_q       <= rd_d;
         wb_valid_q <= wb_valid_d;
         wb_rwe_q   <= wb_rwe_d;
         wb_rd_q    <= wb_rd_d;
         wb_data_q  <= wb_data_d;
         wb_mis_q   <= wb_mis_d;
      end
   end

endmodule
